// File: rtl/sysu_mux_sel_reg.sv
// sysu_mux_sel_reg: registered SRC:1 selector with manual load and scan stepping.
// Define SYSU_MUX_BBM_EN to insert a one-cycle break-before-make blank on switches.
module sysu_mux_sel_reg #(
  parameter int WIDTH = 4,
  parameter int SRC   = 2,
  parameter int DWELL = 8,
  parameter int SEL_W = 4
) (
  input  logic                 CLK,
  input  logic                 CLR_N,
  input  logic [SRC*WIDTH-1:0] D,
  input  logic [SEL_W-1:0]     S,
  input  logic                 LD,
  input  logic                 G,
  input  logic                 SCAN,
  output logic [WIDTH-1:0]     Y,
  output logic [SEL_W-1:0]     SEL_Q,
  output logic                 BUSY
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int NSEL  = 2 ** SEL_W;

  logic [WIDTH-1:0] w_src [NSEL];
  logic [SEL_W-1:0] r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_y;
  logic             r_busy;

  logic             w_ld_ok;
  logic             w_dwell_end;
  logic             w_sw;
  logic [SEL_W-1:0] w_nxt;
  logic [SEL_W-1:0] w_new;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Unused select codes read as zero so the mux index needs no range guard
  for (genvar i = 0; i < NSEL; i++) begin : g_src
    if (i < SRC) begin : g_used
      assign w_src[i] = D[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign w_src[i] = '0;
    end
  end

  assign w_ld_ok     = !SCAN && LD && (int'(S) < SRC) && (S != r_sel);
  assign w_dwell_end = SCAN && (r_cnt == CNT_W'(DWELL - 1));
  assign w_nxt       = (r_sel == SEL_W'(SRC - 1)) ? '0 : r_sel + 1'b1;
  assign w_new       = SCAN ? w_nxt : S;
  assign w_sw        = w_ld_ok || w_dwell_end;
  assign w_cnt_nxt   = (SCAN && !w_dwell_end) ? r_cnt + 1'b1 : '0;

  assign Y     = r_y;
  assign SEL_Q = r_sel;
  assign BUSY  = r_busy;

`ifdef SYSU_MUX_BBM_EN
  typedef enum logic {IDLE, BLANK} state_t;

  state_t           r_state;
  logic [SEL_W-1:0] r_pend;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_pend  <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cnt <= w_cnt_nxt;
          if (w_sw) begin
            r_pend  <= w_new;
            r_y     <= '0;
            r_busy  <= 1'b1;
            r_state <= BLANK;
          end else begin
            r_y <= G ? '0 : w_src[r_sel];
          end
        end
        BLANK: begin
          r_sel   <= r_pend;
          r_y     <= G ? '0 : w_src[r_pend];
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_sel  <= '0;
      r_cnt  <= '0;
      r_y    <= '0;
      r_busy <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= 1'b0;
      if (w_sw) begin
        r_sel <= w_new;
        r_y   <= G ? '0 : w_src[w_new];
      end else begin
        r_y <= G ? '0 : w_src[r_sel];
      end
    end
  end
`endif

endmodule

// File: tb/tb_sysu_mux_sel_reg.sv
// tb_sysu_mux_sel_reg: scoreboard bench for sysu_mux_sel_reg (WIDTH=4, SRC=3, DWELL=3).
// Follows SYSU_MUX_BBM_EN the same way the design does.
module tb_sysu_mux_sel_reg;

  localparam int WIDTH = 4;
  localparam int SRC   = 3;
  localparam int DWELL = 3;
  localparam int SEL_W = 2;

  logic                 CLK = 1'b0;
  logic                 CLR_N;
  logic [SRC*WIDTH-1:0] D;
  logic [SEL_W-1:0]     S;
  logic                 LD;
  logic                 G;
  logic                 SCAN;
  logic [WIDTH-1:0]     Y;
  logic [SEL_W-1:0]     SEL_Q;
  logic                 BUSY;

  sysu_mux_sel_reg #(
    .WIDTH(WIDTH), .SRC(SRC), .DWELL(DWELL), .SEL_W(SEL_W)
  ) dut (
    .CLK(CLK), .CLR_N(CLR_N), .D(D), .S(S), .LD(LD), .G(G),
    .SCAN(SCAN), .Y(Y), .SEL_Q(SEL_Q), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // Expected {BUSY, SEL_Q, Y} per edge
  logic [6:0] sb_q [$];

  int   m_sel, m_pend, m_cnt;
  logic [3:0] m_y;
  logic m_busy, m_blank;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] src(input int i);
    case (i)
      0:       return 4'h5;
      1:       return 4'h9;
      2:       return 4'hA;
      default: return 4'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_sel = 0; m_pend = 0; m_cnt = 0;
    m_y = 4'h0; m_busy = 1'b0; m_blank = 1'b0;
  endtask

  task automatic model_edge();
    bit go;
    int tgt;
    go = 0;
    tgt = 0;
    if (m_blank) begin
      m_sel   = m_pend;
      m_y     = G ? 4'h0 : src(m_pend);
      m_busy  = 1'b0;
      m_blank = 1'b0;
    end else begin
      if (SCAN) begin
        if (m_cnt == DWELL - 1) begin
          go = 1; tgt = (m_sel + 1) % SRC; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end else begin
        m_cnt = 0;
        if (LD && int'(S) < SRC && int'(S) != m_sel) begin
          go = 1; tgt = int'(S);
        end
      end
      if (go) begin
`ifdef SYSU_MUX_BBM_EN
        m_pend = tgt; m_y = 4'h0; m_busy = 1'b1; m_blank = 1'b1;
`else
        m_sel = tgt; m_y = G ? 4'h0 : src(tgt);
`endif
      end else begin
        m_y = G ? 4'h0 : src(m_sel);
      end
    end
  endtask

  task automatic step(input logic ld, input logic [1:0] s,
                      input logic scan, input logic g, input string tag);
    logic [6:0] e;
    @(negedge CLK);
    LD = ld; S = s; SCAN = scan; G = g;
    model_edge();
    sb_q.push_back({m_busy, 2'(m_sel), m_y});
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".Y"},    32'(Y),     32'(e[3:0]));
    chk({tag, ".SEL"},  32'(SEL_Q), 32'(e[5:4]));
    chk({tag, ".BUSY"}, 32'(BUSY),  32'(e[6]));
  endtask

  initial begin
    D = {4'hA, 4'h9, 4'h5};
    S = '0; LD = 0; G = 0; SCAN = 0;
    CLR_N = 0;
    model_reset();
    #12;
    chk("rst.Y", 32'(Y), 32'h0);
    chk("rst.SEL", 32'(SEL_Q), 32'h0);
    chk("rst.BUSY", 32'(BUSY), 32'h0);
    @(negedge CLK);
    CLR_N = 1;

    repeat (3) step(0, 0, 0, 0, "idle");
    chk("idle.D0", 32'(Y), 32'h5);

    step(1, 2, 0, 0, "ld2");
    repeat (3) step(0, 0, 0, 0, "post2");
    chk("ld2.SEL", 32'(SEL_Q), 32'h2);
    chk("ld2.Y", 32'(Y), 32'hA);

    step(1, 3, 0, 0, "ldbad");
    step(1, 2, 0, 0, "ldsame");
    step(0, 0, 0, 0, "hold");

    step(1, 0, 0, 0, "ld0");
    repeat (2) step(0, 0, 0, 0, "post0");

    for (int i = 0; i < 14; i++)
      step(i % 4 == 1, 2'(i % 3), 1, 0, "scan");

    repeat (4) step(0, 0, 1, 1, "gate");
    repeat (4) step(0, 0, 1, 0, "ungate");

    step(0, 0, 0, 0, "scanoff");
    step(1, 2'((m_sel + 1) % SRC), 0, 0, "ldnext");
    repeat (2) step(0, 0, 0, 0, "post");

    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, "rnd");

    repeat (3) step(0, 0, 0, 0, "settle");
    step(1, 2'((m_sel + 1) % SRC), 0, 0, "preclr");
    #2;
    CLR_N = 0;
    #1;
    chk("clr.Y", 32'(Y), 32'h0);
    chk("clr.SEL", 32'(SEL_Q), 32'h0);
    chk("clr.BUSY", 32'(BUSY), 32'h0);
    model_reset();
    @(negedge CLK);
    CLR_N = 1;
    step(0, 0, 0, 0, "after_clr");
    chk("after_clr.D0", 32'(Y), 32'h5);
    repeat (2) step(0, 0, 0, 0, "tail");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
